// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: accumulate-stage state encoding
// and the product width produced by the 4x4 multiplier.
package mac_pkg;

  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } mac_state_t;

endpackage

// File: rtl/mac_acc_adder.sv
// ACC_W-bit accumulator adder: a + zero-extended product, with carry-out
// so the parent can flag overflow past 2^ACC_W-1.
module mac_acc_adder
  import mac_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] a_ext;
  logic [ACC_W:0] b_ext;
  logic [ACC_W:0] total;

  always_comb begin
    a_ext = {1'b0, a};
    b_ext = (ACC_W+1)'(b);
    total = a_ext + b_ext;
    sum   = total[ACC_W-1:0];
    carry = total[ACC_W];
  end

endmodule

// File: rtl/mult_accumulator.sv
// Accumulate stage behind the array multiplier: sums up to VEC_LEN products
// per vector and presents sum, beat count and sticky overflow on a handshake.
module mult_accumulator
  import mac_pkg::*;
#(
  parameter int VEC_LEN = 4,
  parameter int ACC_W   = 12,
  localparam int CNT_W  = $clog2(VEC_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  if (VEC_LEN < 1 || ACC_W < 8) begin : g_bad_param
    $error("mult_accumulator: VEC_LEN must be >= 1 and ACC_W >= 8");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VEC_LEN);

  mac_state_t       state_reg, state_next;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;

  logic             accept;
  logic             first_beat;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [CNT_W-1:0] count_inc;
  logic             close_vec;

  // First beat of a vector adds onto zero so acc starts at the product itself.
  always_comb begin
    accept     = in_valid && in_ready;
    first_beat = (state_reg == IDLE);
    add_a      = first_beat ? '0 : acc_reg;
    count_inc  = first_beat ? CNT_ONE : count_reg + CNT_ONE;
    close_vec  = in_last || (count_inc == CNT_MAX);
  end

  mac_acc_adder #(.ACC_W(ACC_W)) u_adder (
    .a     (add_a),
    .b     (in_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, ACC: if (accept) state_next = close_vec ? HOLD : ACC;
        HOLD:      if (out_ready) state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Handshake flags decode from state alone; no comb path out_ready -> in_ready.
  always_comb begin
    in_ready  = (state_reg != HOLD);
    out_valid = (state_reg == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (clear) begin
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      acc_reg   <= add_sum;
      count_reg <= count_inc;
      ovf_reg   <= (first_beat ? 1'b0 : ovf_reg) | add_carry;
    end
  end

  assign out_sum   = acc_reg;
  assign out_count = count_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
Sequential accumulate stage directly downstream of the 4x4 array multiplier. Consumes its 8-bit unsigned products over a valid/ready handshake and sums a vector of up to VEC_LEN products. Presents the dot-product result, beat count and overflow flag on a registered output handshake. Together with the multiplier it forms a small MAC datapath.

Parameters:
VEC_LEN, 4, products per vector (>=1); vector closes when this many beats are accepted
ACC_W, 12, accumulator width in bits (>=8); default holds 4*225=900 without overflow
CNT_W, derived localparam = $clog2(VEC_LEN+1), width of beat counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort/flush, highest priority after reset
in_valid  input  1  product beat valid
in_ready  output  1  stage can accept a beat
in_prod  input  8  unsigned product from multiplier out[7:0]
in_last  input  1  qualifies accepted beat as final of vector (early close)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  ACC_W  accumulated sum
out_count  output  CNT_W  beats in this vector
out_ovf  output  1  sticky: sum exceeded 2^ACC_W-1 during this vector

Behaviour:
- Reset (rst_n low, async): state IDLE; acc, count, out_ovf, out_valid = 0; in_ready = 1 (state-decoded).
- Clock: one clock, clk; reset is asynchronous, active-low on rst_n; all state flops async-cleared.
- States: IDLE (no beat yet), ACC (>=1 beat taken), HOLD (result presented).
- in_ready = 1 in IDLE/ACC, 0 in HOLD. Decoded from state only, no combinational path from out_ready.
- Beat accepted when in_valid && in_ready. in_prod/in_last ignored otherwise.
- IDLE accept: acc <= zero-extended in_prod; count <= 1; ovf <= 0; -> ACC.
- ACC accept: {carry, acc} <= acc + in_prod (ACC_W+1-bit add); acc wraps modulo 2^ACC_W; ovf <= ovf | carry; count++.
- Close condition on an accepted beat: in_last=1 or post-increment count == VEC_LEN. Next state HOLD, out_valid=1 from the next cycle (1-cycle latency from final beat). With VEC_LEN=1 every beat closes from IDLE.
- HOLD: out_valid, out_sum, out_count, out_ovf held stable until out_valid && out_ready; that cycle -> IDLE, out_valid=0 next cycle. No same-cycle accept of the next beat (min 1 bubble).
- out_sum/out_count/out_ovf are the acc/count/ovf registers; values outside HOLD are don't-care for checking but never X after reset.
- in_valid gaps allowed at any point; accumulator holds.
- clear=1: next cycle state IDLE, acc/count/ovf/out_valid = 0, regardless of state or simultaneous handshakes. A beat presented with clear is dropped.
- Reset mid-vector or mid-HOLD: partial result discarded; no output emitted.
- Elaboration error if VEC_LEN<1 or ACC_W<8.

Decomposition:
- Shared package mac_pkg: state encoding (IDLE=2'd0, ACC=2'd1, HOLD=2'd2) and PROD_W=8 constant shared with the multiplier.
- One sub-module: mac_acc_adder, an ACC_W-bit adder with zero-extended 8-bit operand and carry-out. Parent holds FSM, counter and registers.

Test Plan:
- Reset mid-vector: 2 beats (9,9), then rst_n low 1 cycle -> out_valid 0, in_ready 1; next full vector of 4x1 -> out_sum 4, out_count 4.
- Full vector: 4 back-to-back beats of 225 -> out_valid rises 1 cycle after 4th beat; out_sum 900, out_count 4, out_ovf 0.
- Early close with gaps: beats 6, (2 idle cycles), 10 with in_last -> out_sum 16, out_count 2.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 -> in_ready 0, outputs stable, no beat absorbed; out_ready=1 -> IDLE next cycle, next vector unaffected.
- Overflow (ACC_W=8): beats 200, 100, last -> out_sum 44, out_ovf 1; the following vector 1,1,1,1 -> out_ovf 0, out_sum 4.
- Clear: after 2 beats of 50, pulse clear together with a valid beat of 7 -> beat dropped; next 4 beats of 3 -> out_sum 12, out_count 4.
